// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg: shared state encoding, default command/response bytes and checksum helper.
// UART_BRIDGE_CHECKSUM_EN adds the GET_SUM state.
package uart_bridge_pkg;
  localparam logic [7:0] DEF_CMD_WR  = 8'h57;
  localparam logic [7:0] DEF_CMD_RD  = 8'h52;
  localparam logic [7:0] DEF_RSP_ACK = 8'h06;
  localparam logic [7:0] DEF_RSP_NAK = 8'h15;
  typedef enum logic [3:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
`ifdef UART_BRIDGE_CHECKSUM_EN
    GET_SUM,
`endif
    REG_WR,
    REG_RD,
    RD_CAP,
    SEND,
    WAIT_HI,
    WAIT_LO
  } state_t;
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
    return sum ^ data;
  endfunction
endpackage

// File: rtl/uart_bridge_if.sv
// uart_bridge_if: UART byte handshake plus 8-bit register bus seen by the bridge.
interface uart_bridge_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_error;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       frame_err;
  modport master (
    input  rx_valid, rx_data, rx_error, tx_busy, reg_rdata,
    output tx_start, tx_data, reg_addr, reg_wdata, reg_we, reg_re, frame_err
  );
  modport slave (
    output rx_valid, rx_data, rx_error, tx_busy, reg_rdata,
    input  tx_start, tx_data, reg_addr, reg_wdata, reg_we, reg_re, frame_err
  );
endinterface

// File: rtl/uart_bridge_timeout.sv
// uart_bridge_timeout: inter-byte watchdog; expire is combinational once the count hits TIMEOUT_CYCLES-1.
module uart_bridge_timeout #(
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt;
  assign expire = en && cnt == W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en && !expire) cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: decodes W/R host frames from UART bytes into register bus accesses with a one-byte reply.
// UART_BRIDGE_CHECKSUM_EN appends an XOR checksum byte to every frame.
module uart_reg_bridge
  import uart_bridge_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 5000000,
  parameter logic [7:0] CMD_WR  = DEF_CMD_WR,
  parameter logic [7:0] CMD_RD  = DEF_CMD_RD,
  parameter logic [7:0] RSP_ACK = DEF_RSP_ACK,
  parameter logic [7:0] RSP_NAK = DEF_RSP_NAK
) (
  input logic           clk,
  input logic           rst,
  uart_bridge_if.master b
);
  state_t state, nxt;
  logic wr, expire, framing, collecting, take, abort, drop, is_cmd;
`ifdef UART_BRIDGE_CHECKSUM_EN
  logic [7:0] sum;
  logic       sum_ok;
  assign sum_ok  = b.rx_data == sum;
  assign framing = state inside {GET_ADDR, GET_DATA, GET_SUM};
`else
  assign framing = state inside {GET_ADDR, GET_DATA};
`endif
  assign collecting = framing || state == IDLE;
  assign take       = b.rx_valid && !b.rx_error && collecting;
  assign abort      = framing && (b.rx_error || (expire && !b.rx_valid));
  assign drop       = b.rx_valid && !collecting;
  assign is_cmd     = b.rx_data == CMD_WR || b.rx_data == CMD_RD;
  uart_bridge_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (take),
    .en     (framing),
    .expire (expire)
  );
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (abort) nxt = IDLE;
    else
      case (state)
        IDLE:     if (take) nxt = is_cmd ? GET_ADDR : SEND;
`ifdef UART_BRIDGE_CHECKSUM_EN
        GET_ADDR: if (take) nxt = wr ? GET_DATA : GET_SUM;
        GET_DATA: if (take) nxt = GET_SUM;
        GET_SUM:  if (take) nxt = !sum_ok ? SEND : wr ? REG_WR : REG_RD;
`else
        GET_ADDR: if (take) nxt = wr ? GET_DATA : REG_RD;
        GET_DATA: if (take) nxt = REG_WR;
`endif
        REG_WR:   nxt = SEND;
        REG_RD:   nxt = RD_CAP;
        RD_CAP:   nxt = SEND;
        SEND:     if (!b.tx_busy) nxt = WAIT_HI;
        WAIT_HI:  if (b.tx_busy) nxt = WAIT_LO;
        WAIT_LO:  if (!b.tx_busy) nxt = IDLE;
        default:  nxt = IDLE;
      endcase
  end
  always_comb begin
    b.reg_we    = state == REG_WR;
    b.reg_re    = state == REG_RD;
    b.tx_start  = state == SEND && !b.tx_busy;
    b.frame_err = abort || drop;
  end
  always_ff @(posedge clk)
    if (rst) begin
      b.reg_addr  <= '0;
      b.reg_wdata <= '0;
      b.tx_data   <= '0;
      wr          <= 1'b0;
`ifdef UART_BRIDGE_CHECKSUM_EN
      sum         <= '0;
`endif
    end else begin
      if (take && state == IDLE) begin
        wr <= b.rx_data == CMD_WR;
        if (!is_cmd) b.tx_data <= RSP_NAK;
      end
      if (take && state == GET_ADDR) b.reg_addr <= b.rx_data;
      if (take && state == GET_DATA) b.reg_wdata <= b.rx_data;
`ifdef UART_BRIDGE_CHECKSUM_EN
      if (take) sum <= state == IDLE ? b.rx_data : csum_add(sum, b.rx_data);
      if (take && state == GET_SUM && !sum_ok) b.tx_data <= RSP_NAK;
`endif
      if (state == REG_WR) b.tx_data <= RSP_ACK;
      if (state == RD_CAP) b.tx_data <= b.reg_rdata;
    end
endmodule

// File: tb/tb_uart_reg_bridge.sv
// tb_uart_reg_bridge: table vectors, hand-built corner sequences and random frames checked against a frame-level model.
module tb_uart_reg_bridge;
  import uart_bridge_pkg::*;
  localparam int TO = 100;
  typedef struct {
    bit         we;
    bit         re;
    logic [7:0] addr;
    logic [7:0] wd;
    logic [7:0] rsp;
    int         lat;
  } exp_t;
  typedef struct {
    logic [7:0] d [4];
    int         n;
    exp_t       e;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_busy = 1'b0;
  int uart_dur = 8;
  int uart_cnt = 0;
  int cyc = 0, checks = 0, errors = 0;
  int we_n = 0, re_n = 0, ts_n = 0, fe_n = 0, viol_n = 0;
  int ts_cyc = 0, fe_cyc = 0, rx_cyc = 0;
  logic [7:0] we_a = 0, we_d = 0, re_a = 0, ts_d = 0;
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  vec_t tbl [$];
  uart_bridge_if bus();
  uart_reg_bridge #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .b(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign bus.tx_busy = force_busy || uart_cnt != 0;
  always @(posedge clk) begin
    uart_cnt <= bus.tx_start ? uart_dur : (uart_cnt != 0 ? uart_cnt - 1 : 0);
    if (bus.reg_we) mem[bus.reg_addr] <= bus.reg_wdata;
    bus.reg_rdata <= bus.reg_re ? mem[bus.reg_addr] : 8'($urandom);
  end
  always @(negedge clk) begin
    if (bus.reg_we) begin we_n++; we_a = bus.reg_addr; we_d = bus.reg_wdata; end
    if (bus.reg_re) begin re_n++; re_a = bus.reg_addr; end
    if (bus.tx_start) begin ts_n++; ts_d = bus.tx_data; ts_cyc = cyc; if (bus.tx_busy) viol_n++; end
    if (bus.frame_err) begin fe_n++; fe_cyc = cyc; end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic send_byte(input logic [7:0] d);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1; bus.rx_data = d; rx_cyc = cyc;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask
  task automatic pulse_err(input bit with_valid);
    @(posedge clk); #1;
    bus.rx_error = 1'b1; bus.rx_valid = with_valid; bus.rx_data = 8'h10; rx_cyc = cyc;
    @(posedge clk); #1;
    bus.rx_error = 1'b0; bus.rx_valid = 1'b0;
  endtask
  task automatic outputs_zero(input string nm);
    chk(nm, {bus.tx_start, bus.tx_data, bus.reg_addr, bus.reg_wdata, bus.reg_we, bus.reg_re, bus.frame_err}, 0);
  endtask
  function automatic vec_t mk(input logic [7:0] d0, d1, d2, d3, input int n, input bit we, re,
                              input logic [7:0] a, wd, rsp, input int lat);
    vec_t v;
    v.d = '{d0, d1, d2, d3};
    v.n = n;
    v.e.we = we; v.e.re = re; v.e.addr = a; v.e.wd = wd; v.e.rsp = rsp; v.e.lat = lat;
    return v;
  endfunction
  task automatic model(input logic [7:0] d [4], input int n, output exp_t e);
    logic [7:0] x = 8'h00;
    bit ok = 1'b1;
    e = '{default: 0};
`ifdef UART_BRIDGE_CHECKSUM_EN
    for (int i = 0; i < n - 1; i++) x ^= d[i];
    ok = x == d[n-1];
`endif
    if (d[0] != DEF_CMD_WR && d[0] != DEF_CMD_RD || !ok) begin
      e.rsp = DEF_RSP_NAK; e.lat = 1;
    end else if (d[0] == DEF_CMD_WR) begin
      e.we = 1; e.addr = d[1]; e.wd = d[2]; e.rsp = DEF_RSP_ACK; e.lat = 2;
      ref_mem[d[1]] = d[2];
    end else begin
      e.re = 1; e.addr = d[1]; e.rsp = ref_mem[d[1]]; e.lat = 3;
    end
  endtask
  task automatic check_frame(input string nm, input exp_t e, input int b_we, b_re, b_ts, b_fe);
    for (int k = 0; k < 300 && !(ts_n > b_ts && !bus.tx_busy); k++) tick();
    tick(2);
    chk({nm, "_we_count"}, we_n - b_we, e.we);
    chk({nm, "_re_count"}, re_n - b_re, e.re);
    if (e.we) begin
      chk({nm, "_we_addr"}, we_a, e.addr);
      chk({nm, "_we_data"}, we_d, e.wd);
    end
    if (e.re) chk({nm, "_re_addr"}, re_a, e.addr);
    chk({nm, "_tx_count"}, ts_n - b_ts, 1);
    chk({nm, "_tx_data"}, ts_d, e.rsp);
    chk({nm, "_tx_latency"}, ts_cyc - rx_cyc, e.lat);
    chk({nm, "_frame_err"}, fe_n - b_fe, 0);
  endtask
  task automatic run_frame(input string nm, input logic [7:0] d [4], input int n, input exp_t e);
    int b_we = we_n, b_re = re_n, b_ts = ts_n, b_fe = fe_n;
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick($urandom_range(0, 3));
      send_byte(d[i]);
    end
    check_frame(nm, e, b_we, b_re, b_ts, b_fe);
  endtask
  task automatic frame_auto(input string nm, input logic [7:0] c, a, w, input bit corrupt);
    logic [7:0] d [4] = '{default: 8'h00};
    logic [7:0] x = 8'h00;
    int n;
    exp_t e;
    d[0] = c; d[1] = a; d[2] = w;
    n = c == DEF_CMD_WR ? 3 : c == DEF_CMD_RD ? 2 : 1;
    if (n > 1) begin
      for (int i = 0; i < n; i++) x ^= d[i];
`ifdef UART_BRIDGE_CHECKSUM_EN
      d[n] = corrupt ? ~x : x;
      n++;
`endif
    end
    model(d, n, e);
    run_frame(nm, d, n, e);
  endtask

  initial begin
    int t0, b_we, b_re, b_ts, b_fe;
    exp_t e;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.rx_error = 1'b0;
`ifdef UART_BRIDGE_CHECKSUM_EN
    tbl.push_back(mk(8'h57, 8'h10, 8'hA5, 8'hE2, 4, 1, 0, 8'h10, 8'hA5, 8'h06, 2));
    tbl.push_back(mk(8'h57, 8'h10, 8'hA5, 8'h00, 4, 0, 0, 8'h00, 8'h00, 8'h15, 1));
    tbl.push_back(mk(8'h57, 8'h3C, 8'hC7, 8'hAC, 4, 1, 0, 8'h3C, 8'hC7, 8'h06, 2));
    tbl.push_back(mk(8'h52, 8'h3C, 8'h6E, 8'h00, 3, 0, 1, 8'h3C, 8'h00, 8'hC7, 3));
    tbl.push_back(mk(8'h41, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h15, 1));
    tbl.push_back(mk(8'h52, 8'h10, 8'h42, 8'h00, 3, 0, 1, 8'h10, 8'h00, 8'hA5, 3));
    tbl.push_back(mk(8'h52, 8'h10, 8'h43, 8'h00, 3, 0, 0, 8'h00, 8'h00, 8'h15, 1));
`else
    tbl.push_back(mk(8'h57, 8'h10, 8'hA5, 8'h00, 3, 1, 0, 8'h10, 8'hA5, 8'h06, 2));
    tbl.push_back(mk(8'h57, 8'h3C, 8'hC7, 8'h00, 3, 1, 0, 8'h3C, 8'hC7, 8'h06, 2));
    tbl.push_back(mk(8'h52, 8'h3C, 8'h00, 8'h00, 2, 0, 1, 8'h3C, 8'h00, 8'hC7, 3));
    tbl.push_back(mk(8'h41, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h15, 1));
    tbl.push_back(mk(8'h52, 8'h10, 8'h00, 8'h00, 2, 0, 1, 8'h10, 8'h00, 8'hA5, 3));
    tbl.push_back(mk(8'h57, 8'hFF, 8'h5A, 8'h00, 3, 1, 0, 8'hFF, 8'h5A, 8'h06, 2));
    tbl.push_back(mk(8'h52, 8'hFF, 8'h00, 8'h00, 2, 0, 1, 8'hFF, 8'h00, 8'h5A, 3));
    tbl.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h15, 1));
`endif
    tick(3);
    outputs_zero("reset_outputs");
    rst = 1'b0;
    tick(2);
    foreach (tbl[i]) begin
      run_frame($sformatf("vec%0d", i), tbl[i].d, tbl[i].n, tbl[i].e);
      if (tbl[i].e.we) ref_mem[tbl[i].e.addr] = tbl[i].e.wd;
    end
    b_we = we_n; b_ts = ts_n; b_fe = fe_n;
    send_byte(8'h57);
    send_byte(8'h10);
    t0 = rx_cyc;
    for (int k = 0; k < TO + 50 && fe_n == b_fe; k++) tick();
    tick(3);
    chk("timeout_err_count", fe_n - b_fe, 1);
    chk("timeout_latency", fe_cyc - t0, TO);
    chk("timeout_no_we", we_n - b_we, 0);
    chk("timeout_no_rsp", ts_n - b_ts, 0);
    frame_auto("after_timeout", 8'h52, 8'h00, 8'h00, 0);
    b_we = we_n; b_re = re_n; b_ts = ts_n; b_fe = fe_n;
    send_byte(8'h57);
    t0 = rx_cyc;
    while (cyc < t0 + 99) tick();
    send_byte(8'h20);
    send_byte(8'h66);
`ifdef UART_BRIDGE_CHECKSUM_EN
    send_byte(8'h57 ^ 8'h20 ^ 8'h66);
`endif
    e = '{we: 1, re: 0, addr: 8'h20, wd: 8'h66, rsp: 8'h06, lat: 2};
    check_frame("edge_valid_wins", e, b_we, b_re, b_ts, b_fe);
    ref_mem[8'h20] = 8'h66;
    b_we = we_n; b_ts = ts_n; b_fe = fe_n;
    send_byte(8'h57);
    tick(2);
    pulse_err(1'b1);
    chk("rxerr_err_cycle", fe_cyc, rx_cyc);
    tick(10);
    chk("rxerr_err_count", fe_n - b_fe, 1);
    chk("rxerr_no_we", we_n - b_we, 0);
    chk("rxerr_no_rsp", ts_n - b_ts, 0);
    pulse_err(1'b0);
    tick(3);
    chk("rxerr_idle_ignored", fe_n - b_fe, 1);
    frame_auto("after_rxerr", 8'h52, 8'h20, 8'h00, 0);
    force_busy = 1'b1;
    b_we = we_n; b_ts = ts_n; b_fe = fe_n;
    send_byte(8'h57);
    send_byte(8'h20);
    send_byte(8'h33);
`ifdef UART_BRIDGE_CHECKSUM_EN
    send_byte(8'h57 ^ 8'h20 ^ 8'h33);
`endif
    tick(50);
    chk("busy_holds_tx", ts_n - b_ts, 0);
    force_busy = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 20 && ts_n == b_ts; k++) tick();
    chk("busy_tx_cycle", ts_cyc, t0);
    chk("busy_tx_data", ts_d, 8'h06);
    send_byte(8'h41);
    chk("drop_err_cycle", fe_cyc, rx_cyc);
    for (int k = 0; k < 50 && bus.tx_busy; k++) tick();
    tick(5);
    chk("drop_err_count", fe_n - b_fe, 1);
    chk("drop_no_extra_rsp", ts_n - b_ts, 1);
    chk("busy_we_count", we_n - b_we, 1);
    chk("busy_we_addr", we_a, 8'h20);
    ref_mem[8'h20] = 8'h33;
    b_we = we_n; b_ts = ts_n;
    send_byte(8'h57);
    send_byte(8'h10);
`ifdef UART_BRIDGE_CHECKSUM_EN
    send_byte(8'hA5);
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    outputs_zero("midframe_reset_outputs");
    rst = 1'b0;
    tick(TO + 20);
    chk("midframe_reset_no_we", we_n - b_we, 0);
    chk("midframe_reset_no_rsp", ts_n - b_ts, 0);
    frame_auto("after_reset", 8'h52, 8'h10, 8'h00, 0);
    for (int i = 0; i < 40; i++) begin
      int k = $urandom_range(0, 9);
      logic [7:0] c = k < 4 ? DEF_CMD_WR : k < 8 ? DEF_CMD_RD : 8'($urandom);
      if (k >= 8 && (c == DEF_CMD_WR || c == DEF_CMD_RD)) c = 8'h00;
      uart_dur = $urandom_range(1, 12);
      frame_auto($sformatf("rand%0d", i), c, 8'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 4) == 0);
    end
    chk("tx_start_while_busy", viol_n, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
